serdes_tx_arbiter: RTL and testbench

//  Shares one P2S serializer among N_REQ byte requesters. Round-robin grants one

---
 rtl/serdes_tx_arbiter_pkg.sv | 14 +
 rtl/serdes_tx_arbiter_rr.sv | 30 +++
 rtl/serdes_tx_arbiter.sv | 112 +++++++++++
 tb/tb_serdes_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_tx_arbiter_pkg.sv
// Shared types and constants for the serializer transmit arbiter.
package serdes_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StHold
  } state_e;

  // Wide enough for FRAME_CYC up to 255.
  localparam int unsigned HoldW     = 8;
  localparam int unsigned FrameCntW = 16;

endpackage

// File: rtl/serdes_tx_arbiter_rr.sv
// Combinational round-robin picker: the search starts just after the last winner.
module serdes_tx_arbiter_rr #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((32'(last) + i) % N_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Grants one requester byte per frame slot to a shared P2S serializer, round-robin,
// emitting a single-cycle SOF and holding the byte for FRAME_CYC cycles.
module serdes_tx_arbiter
  import serdes_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned FRAME_CYC = 10,
  parameter int unsigned ID_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   din,
  output logic [N_REQ-1:0]      ack,
  output logic                  p2s_sof,
  output logic [DW-1:0]         p2s_din,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  busy,
  output logic [FrameCntW-1:0]  frame_cnt
);

  state_e                 state_q;
  logic [HoldW-1:0]       hold_q;
  logic [ID_W-1:0]        last_q;
  logic [N_REQ-1:0]       ack_q;
  logic                   sof_q;
  logic [DW-1:0]          din_q;
  logic [ID_W-1:0]        gnt_id_q;
  logic                   busy_q;
  logic [FrameCntW-1:0]   frame_cnt_q;

  logic [N_REQ-1:0] win_gnt;
  logic [ID_W-1:0]  win_id;
  logic             win_any;
  logic [DW-1:0]    win_byte;
  logic             decide;

  serdes_tx_arbiter_rr #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req    (req),
    .last   (last_q),
    .gnt    (win_gnt),
    .gnt_id (win_id),
    .any    (win_any)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_gnt[i]) win_byte = din[i*DW +: DW];
    end
  end

  assign decide = en && win_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      ack_q       <= '0;
      sof_q       <= 1'b0;
      din_q       <= '0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      ack_q <= '0;
      sof_q <= 1'b0;
      unique case (state_q)
        StIdle, StHold: begin
          if (state_q == StHold && hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (decide) begin
            // Decision edge: latch the winner's byte so later DIN changes are ignored.
            state_q  <= StSend;
            last_q   <= win_id;
            gnt_id_q <= win_id;
            din_q    <= win_byte;
            ack_q    <= win_gnt;
            sof_q    <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StSend: begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
          hold_q      <= HoldW'(FRAME_CYC - 2);
          state_q     <= StHold;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign p2s_sof   = sof_q;
  assign p2s_din   = din_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Self-checking bench: slot-position reference model compared every cycle, plus directed scenarios.
module tb_serdes_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int F  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0]  ack;
  logic          p2s_sof;
  logic [DW-1:0] p2s_din;
  logic [1:0]    gnt_id;
  logic          busy;
  logic [15:0]   frame_cnt;

  serdes_tx_arbiter #(
    .N_REQ     (N),
    .DW        (DW),
    .FRAME_CYC (F),
    .ID_W      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .p2s_sof   (p2s_sof),
    .p2s_din   (p2s_din),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #4 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a slot is F cycles long, position 0 is the SOF cycle.
  bit          m_busy;
  int          m_pos;
  int          m_last;
  int          m_w;
  int          m_idx;
  logic [N-1:0]  m_ack;
  logic          m_sof;
  logic [DW-1:0] m_din;
  logic [1:0]    m_gnt;
  logic [15:0]   m_frame;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_pos = 0; m_last = N - 1; m_ack = '0; m_sof = 0;
      m_din = '0; m_gnt = '0; m_frame = '0;
    end else begin
      m_sof = 0;
      m_ack = '0;
      if (m_busy && m_pos == 0) m_frame = m_frame + 16'd1;
      if (m_busy && m_pos < F - 1) begin
        m_pos++;
      end else begin
        m_w = -1;
        if (en) begin
          for (int k = 1; k <= N; k++) begin
            m_idx = (m_last + k) % N;
            if (m_w < 0 && req[m_idx]) m_w = m_idx;
          end
        end
        if (m_w >= 0) begin
          m_busy = 1; m_pos = 0; m_sof = 1;
          m_ack  = N'(1 << m_w);
          m_din  = din[m_w*DW +: DW];
          m_gnt  = 2'(m_w);
          m_last = m_w;
        end else begin
          m_busy = 0;
        end
      end
    end
    #2;
    chk("sof", 32'(p2s_sof), 32'(m_sof));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("p2s_din", 32'(p2s_din), 32'(m_din));
    chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
  end

  // Waits (bounded) for the next SOF; returns granted id and the cycle it appeared.
  task automatic wait_sof(output int id, output int at);
    id = -1;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #3;
      if (p2s_sof === 1'b1) begin
        id = int'(gnt_id);
        at = cyc;
        return;
      end
    end
    chk("sof_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_sof(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #3;
      if (p2s_sof === 1'b1) n++;
    end
  endtask

  int id, at, t0, prev, n;
  int exp_ord3 [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_b3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  int exp_ord4 [4] = '{0, 1, 0, 1};

  initial begin
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request with 1-cycle latency.
    @(negedge clk);
    din[23:16] = 8'hA5; req = 4'b0100; en = 1'b1; t0 = cyc;
    wait_sof(id, at);
    chk("t2_gnt", 32'(id), 32'd2);
    chk("t2_lat", 32'(at - t0), 32'd1);
    chk("t2_ack", 32'(ack), 32'b0100);
    chk("t2_din", 32'(p2s_din), 32'hA5);
    @(negedge clk);
    req = '0; din[23:16] = 8'h00;
    repeat (11) @(negedge clk);
    chk("t2_frame", 32'(frame_cnt), 32'd1);

    // Reset mid-slot, then priority restarts from requester 0 onward.
    req = 4'b0010;
    wait_sof(id, at);
    chk("t1_first", 32'(id), 32'd1);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_din", 32'(p2s_din), 32'd0);
    chk("t1_rst_frame", 32'(frame_cnt), 32'd0);
    chk("t1_rst_gnt", 32'(gnt_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    wait_sof(id, at);
    chk("t1_gnt3", 32'(id), 32'd3);
    @(negedge clk);
    req = '0;
    repeat (12) @(negedge clk);

    // All requesting: rotation with exact period.
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_sof(id, at);
      chk("t3_order", 32'(id), 32'(exp_ord3[k]));
      chk("t3_byte", 32'(p2s_din), 32'(exp_b3[k]));
      if (prev >= 0) chk("t3_period", 32'(at - prev), 32'(F));
      prev = at;
    end
    @(negedge clk);
    req = '0;
    repeat (12) @(negedge clk);

    // Fairness: requester 1 joins while 0 stays high.
    req = 4'b0001;
    wait_sof(id, at);
    chk("t4_order", 32'(id), 32'(exp_ord4[0]));
    @(negedge clk);
    req = 4'b0011;
    for (int k = 1; k < 4; k++) begin
      wait_sof(id, at);
      chk("t4_order", 32'(id), 32'(exp_ord4[k]));
    end
    @(negedge clk);
    req = '0;
    repeat (12) @(negedge clk);

    // EN drop during hold: slot completes, no further SOF until EN returns.
    req = 4'b0100;
    wait_sof(id, at);
    chk("t5_gnt", 32'(id), 32'd2);
    repeat (3) @(negedge clk);
    en = 1'b0;
    count_sof(20, n);
    chk("t5_nosof", 32'(n), 32'd0);
    @(negedge clk);
    en = 1'b1; t0 = cyc;
    wait_sof(id, at);
    chk("t5_lat", 32'(at - t0), 32'd1);
    chk("t5_gnt2", 32'(id), 32'd2);
    @(negedge clk);
    req = '0;
    repeat (12) @(negedge clk);

    // Withdrawn request during hold is never granted.
    req = 4'b0001;
    wait_sof(id, at);
    chk("t6_gnt", 32'(id), 32'd0);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    count_sof(20, n);
    chk("t6_nosof", 32'(n), 32'd0);

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    m_frame = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    @(negedge clk);
    chk("t6_preload", 32'(frame_cnt), 32'hFFFF);
    req = 4'b0001;
    wait_sof(id, at);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    chk("t6_wrap", 32'(frame_cnt), 32'd0);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
